// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Request/response bundle for one requester of the data-memory arbiter.
//   The same interface type is used for both port A (pipeline MEM stage) and
//   port B (debug/loader master).
//   Signals:
//     req      requester -> arbiter  request, held with the fields until gnt
//     write    requester -> arbiter  1 = write, 0 = read
//     address  requester -> arbiter  word address
//     wdata    requester -> arbiter  write data
//     gnt      arbiter -> requester  1-cycle pulse, request accepted
//     rvalid   arbiter -> requester  1-cycle pulse, rdata valid
//     rdata    arbiter -> requester  read data, holds until the next rvalid
//   Modports: master (requester side), slave (arbiter side).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, write, address, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, write, address, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter/sequencer in front of the single-ported data memory.
//   Accepts one request at a time, drives registered read/write strobes to the
//   memory and returns read data with a one-cycle valid pulse. Round-robin on
//   conflict; the losing requester keeps its request up until granted.
//   Sequence: IDLE -> ISSUE -> (RESP for reads) -> IDLE.
//   Ports:
//     clock, reset   rising-edge clock, synchronous active-high reset
//     a, b           dmem_arbiter_if.slave requester ports (A = MEM stage, B = debug)
//     mem_address    address to data memory
//     mem_in         write data to data memory
//     mem_read       read strobe (one cycle, in ISSUE)
//     mem_write      write strobe (one cycle, in ISSUE)
//     mem_out        data from data memory, valid the cycle after mem_read
//     busy           1 whenever the sequencer is not in IDLE
//   Optional build macro DMEM_ARB_STATS_EN adds a_grant_cnt, b_grant_cnt and
//   conflict_cnt (32-bit wrapping event counters).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    dmem_arbiter_if.slave     a,
    dmem_arbiter_if.slave     b,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       a_grant_cnt,
    output logic [31:0]       b_grant_cnt,
    output logic [31:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              last_b_r;     // 1: the most recent grant went to port B
    logic              port_b_r;     // port owning the transaction in flight
    logic              write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [DATA_W-1:0] a_rdata_r;
    logic [DATA_W-1:0] b_rdata_r;

    logic              gnt_a_s;
    logic              gnt_b_s;
    logic              grant_s;
    logic              sel_write_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              resp_a_s;
    logic              resp_b_s;

    // Next-state and grant decision; grants are only ever given from IDLE.
    always_comb begin
        state_s = state_r;
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (a.req && b.req) begin
                    // Conflict: the port not served last time wins.
                    if (last_b_r) begin
                        gnt_a_s = 1'b1;
                    end else begin
                        gnt_b_s = 1'b1;
                    end
                end else if (a.req) begin
                    gnt_a_s = 1'b1;
                end else if (b.req) begin
                    gnt_b_s = 1'b1;
                end else begin
                    gnt_a_s = 1'b0;
                end
                if (gnt_a_s || gnt_b_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (write_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Select the fields of the port being granted so they can be latched.
    always_comb begin
        grant_s = gnt_a_s | gnt_b_s;
        if (gnt_b_s) begin
            sel_write_s = b.write;
            sel_addr_s  = b.address;
            sel_wdata_s = b.wdata;
        end else begin
            sel_write_s = a.write;
            sel_addr_s  = a.address;
            sel_wdata_s = a.wdata;
        end
    end

    // State register, request latch, memory strobes and read-data holding registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            last_b_r    <= 1'b1;
            port_b_r    <= 1'b0;
            write_r     <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            a_rdata_r   <= {DATA_W{1'b0}};
            b_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (grant_s) begin
                last_b_r    <= gnt_b_s;
                port_b_r    <= gnt_b_s;
                write_r     <= sel_write_s;
                addr_r      <= sel_addr_s;
                wdata_r     <= sel_wdata_s;
                // Strobes are set on the grant edge so they are high exactly during ISSUE.
                mem_read_r  <= ~sel_write_s;
                mem_write_r <= sel_write_s;
            end else begin
                mem_read_r  <= 1'b0;
                mem_write_r <= 1'b0;
            end
            if (resp_a_s) begin
                a_rdata_r <= mem_out;
            end
            if (resp_b_s) begin
                b_rdata_r <= mem_out;
            end
        end
    end

    // Response pulses are suppressed while reset is asserted so an aborted read never reports.
    assign resp_a_s = (state_r == ST_RESP) & ~port_b_r & ~reset;
    assign resp_b_s = (state_r == ST_RESP) &  port_b_r & ~reset;

    assign a.gnt    = gnt_a_s & ~reset;
    assign b.gnt    = gnt_b_s & ~reset;
    assign a.rvalid = resp_a_s;
    assign b.rvalid = resp_b_s;
    // mem_out is forwarded during RESP so data arrives together with rvalid.
    assign a.rdata  = resp_a_s ? mem_out : a_rdata_r;
    assign b.rdata  = resp_b_s ? mem_out : b_rdata_r;

    assign mem_address = addr_r;
    assign mem_in      = wdata_r;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign busy        = (state_r != ST_IDLE);

`ifdef DMEM_ARB_STATS_EN
    // Grant and conflict event counters; wrap naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_grant_cnt  <= 32'd0;
            b_grant_cnt  <= 32'd0;
            conflict_cnt <= 32'd0;
        end else begin
            if (gnt_a_s) begin
                a_grant_cnt <= a_grant_cnt + 32'd1;
            end
            if (gnt_b_s) begin
                b_grant_cnt <= b_grant_cnt + 32'd1;
            end
            if ((state_r == ST_IDLE) && a.req && b.req) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
